// File: rtl/game_scheduler.sv
// game_scheduler: buffers SPI command bytes in a small FIFO, merges them with
// a periodic gravity tick into single-step requests for the game executioner
// (valid/done handshake), and publishes each finished step on the next VGA
// frame boundary.
// Optional build macro: GAME_SCHED_PAUSE_CMD_EN -- command byte 0x06 toggles
// an internal pause flag that freezes gravity alongside the `paused` port.
module game_scheduler #(
    parameter int unsigned GRAVITY_DIV  = 10_000_000,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned MAX_MOVE_RUN = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    cmd_byte,
    input  logic                          cmd_valid,
    input  logic                          paused,
    input  logic                          frame_start,
    output logic                          step_valid,
    output logic [2:0]                    step_move,
    input  logic                          step_done,
    output logic                          frame_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(GRAVITY_DIV);
    localparam int unsigned RW = $clog2(MAX_MOVE_RUN + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    state_t          state;
    logic [2:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   grav_cnt;
    logic            grav_pend;
    logic [RW-1:0]   run_cnt;

    logic            cmd_ok;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            drop;
    logic            take_cmd;
    logic            take_grav;
    logic            eff_pause;
    logic            grav_tick;

`ifdef GAME_SCHED_PAUSE_CMD_EN
    logic            pause_flag;
    logic            pause_toggle;

    // Pause command: 0x06 flips the internal pause flag and is never queued
    always_comb begin
        pause_toggle = cmd_valid && (cmd_byte == 8'h06);
        eff_pause    = paused | pause_flag;
    end

    // Internal pause flag register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pause_flag <= 1'b0;
        end else if (pause_toggle) begin
            pause_flag <= ~pause_flag;
        end
    end
`else
    // Only the external level pauses gravity in this build
    always_comb begin
        eff_pause = paused;
    end
`endif

    // Command decode, FIFO status and the IDLE-state scheduling decision
    always_comb begin
        cmd_ok     = cmd_valid && (cmd_byte[7:3] == 5'd0) &&
                     (cmd_byte[2:0] >= 3'd1) && (cmd_byte[2:0] <= 3'd4);
        fifo_full  = (fifo_level == LW'(FIFO_DEPTH));
        fifo_empty = (fifo_level == '0);
        // A queued move wins unless gravity has waited through a full move run
        take_cmd   = (state == IDLE) && !fifo_empty &&
                     ((run_cnt < RW'(MAX_MOVE_RUN)) || !grav_pend);
        take_grav  = (state == IDLE) && !take_cmd && grav_pend;
        // At full, a same-cycle pop frees the slot the push needs
        push       = cmd_ok && (!fifo_full || take_cmd);
        drop       = cmd_ok && fifo_full && !take_cmd;
        grav_tick  = !eff_pause && (grav_cnt == CW'(GRAVITY_DIV - 1));
    end

    // FIFO storage; contents need no reset because occupancy gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_byte[2:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (take_cmd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, take_cmd})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Gravity counter and non-accumulating pending flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grav_cnt  <= '0;
            grav_pend <= 1'b0;
        end else begin
            if (!eff_pause) begin
                grav_cnt <= grav_tick ? '0 : grav_cnt + CW'(1);
            end
            // Issuing gravity consumes the pending tick; a coincident tick is absorbed
            if (take_grav) begin
                grav_pend <= 1'b0;
            end else if (grav_tick) begin
                grav_pend <= 1'b1;
            end
        end
    end

    // Count moves issued while gravity waits; any gravity step restarts the run
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_cnt <= '0;
        end else if (take_grav) begin
            run_cnt <= '0;
        end else if (take_cmd && grav_pend) begin
            run_cnt <= run_cnt + RW'(1);
        end
    end

    // Step sequencer: issue, wait for done, publish on the frame boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            step_valid  <= 1'b0;
            step_move   <= 3'd0;
            frame_ready <= 1'b0;
        end else begin
            frame_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_cmd) begin
                        step_move  <= mem[rd_ptr];
                        step_valid <= 1'b1;
                        state      <= BUSY;
                    end else if (take_grav) begin
                        step_move  <= 3'd0;
                        step_valid <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (step_done) begin
                        step_valid <= 1'b0;
                        state      <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    if (frame_start) begin
                        frame_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    step_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_scheduler.sv
// Directed bench for game_scheduler with GRAVITY_DIV=8, FIFO_DEPTH=4,
// MAX_MOVE_RUN=2. Inputs change and outputs are sampled 1 ns after posedge.
module tb_game_scheduler;

    logic       clk;
    logic       reset_n;
    logic [7:0] cmd_byte;
    logic       cmd_valid;
    logic       paused;
    logic       frame_start;
    logic       step_valid;
    logic [2:0] step_move;
    logic       step_done;
    logic       frame_ready;
    logic [2:0] fifo_level;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    game_scheduler #(
        .GRAVITY_DIV  (8),
        .FIFO_DEPTH   (4),
        .MAX_MOVE_RUN (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_byte    (cmd_byte),
        .cmd_valid   (cmd_valid),
        .paused      (paused),
        .frame_start (frame_start),
        .step_valid  (step_valid),
        .step_move   (step_move),
        .step_done   (step_done),
        .frame_ready (frame_ready),
        .fifo_level  (fifo_level),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic [7:0] b);
        cmd_byte  = b;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Complete the current step: done, then frame_start, ending at M+2
    task automatic finish_step();
        step_done = 1'b1;
        tick();
        step_done = 1'b0;
        chk("done_drops_valid", step_valid, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("publish_pulse", frame_ready, 1);
        tick();
        chk("publish_single", frame_ready, 0);
    endtask

    logic [7:0] bad_cmds [6];
    logic [2:0] exp_a [4];
    logic [2:0] exp_b [5];

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        bad_cmds = '{8'h00, 8'h05, 8'h07, 8'h09, 8'h81, 8'hFF};
        exp_a    = '{3'd3, 3'd4, 3'd1, 3'd3};
        exp_b    = '{3'd1, 3'd2, 3'd0, 3'd3, 3'd4};

        reset_n     = 1'b0;
        cmd_byte    = 8'h00;
        cmd_valid   = 1'b0;
        paused      = 1'b0;
        frame_start = 1'b0;
        step_done   = 1'b0;
        tick();
        tick();
        chk("rst_step_valid", step_valid, 0);
        chk("rst_step_move", step_move, 0);
        chk("rst_frame_ready", frame_ready, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);

        // Gravity only: counter 0..7, pending set on edge 8, step on edge 9
        reset_n = 1'b1;
        repeat (7) tick();
        chk("grav_edge7", step_valid, 0);
        tick();
        chk("grav_edge8", step_valid, 0);
        tick();
        chk("grav_edge9_valid", step_valid, 1);
        chk("grav_edge9_move", step_move, 0);
        step_done = 1'b1;
        tick();
        step_done = 1'b0;
        chk("grav_done", step_valid, 0);
        tick();
        tick();
        chk("publish_wait", frame_ready, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("grav_publish", frame_ready, 1);
        tick();
        chk("grav_publish_once", frame_ready, 0);
        chk("grav_idle14", step_valid, 0);
        tick();
        chk("grav_idle15", step_valid, 0);
        tick();
        chk("grav_edge16", step_valid, 0);
        tick();
        chk("grav_edge17_valid", step_valid, 1);
        chk("grav_edge17_move", step_move, 0);
        paused = 1'b1;
        finish_step();
        chk("paused_idle", step_valid, 0);

        // Strobes outside their states are ignored
        step_done   = 1'b1;
        frame_start = 1'b1;
        tick();
        step_done   = 1'b0;
        frame_start = 1'b0;
        chk("stray_frame_ready", frame_ready, 0);
        chk("stray_step_valid", step_valid, 0);
        tick();
        chk("stray_frame_ready2", frame_ready, 0);

        // Command latency: level at N+1, step at N+2 with FIFO drained
        push_cmd(8'h01);
        chk("lat_level_n1", fifo_level, 1);
        chk("lat_valid_n1", step_valid, 0);
        tick();
        chk("lat_valid_n2", step_valid, 1);
        chk("lat_move_n2", step_move, 1);
        chk("lat_level_n2", fifo_level, 0);
        step_done = 1'b1;
        tick();
        step_done = 1'b0;
        repeat (3) tick();
        chk("no_latched_frame", frame_ready, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("lat_publish", frame_ready, 1);
        tick();

        // Invalid command bytes are ignored without overflow
        for (int i = 0; i < 6; i++) begin
            push_cmd(bad_cmds[i]);
        end
        tick();
        chk("bad_level", fifo_level, 0);
        chk("bad_overflow", overflow, 0);
        chk("bad_valid", step_valid, 0);
`ifndef GAME_SCHED_PAUSE_CMD_EN
        push_cmd(8'h06);
        tick();
        chk("cmd06_level", fifo_level, 0);
        chk("cmd06_valid", step_valid, 0);
        chk("cmd06_overflow", overflow, 0);
`endif

        // Overflow: four queue behind a busy step, fifth dropped
        push_cmd(8'h01);
        tick();
        chk("ovf_busy_move", step_move, 1);
        push_cmd(8'h02);
        push_cmd(8'h03);
        push_cmd(8'h04);
        push_cmd(8'h01);
        chk("ovf_full_level", fifo_level, 4);
        chk("ovf_not_yet", overflow, 0);
        push_cmd(8'h02);
        chk("ovf_level", fifo_level, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_hold_valid", step_valid, 1);
        chk("ovf_hold_move", step_move, 1);
        step_done = 1'b1;
        tick();
        step_done = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("ovf_publish", frame_ready, 1);
        // Push lands on the same edge as the pop at full
        push_cmd(8'h03);
        chk("pushpop_move", step_move, 2);
        chk("pushpop_valid", step_valid, 1);
        chk("pushpop_level", fifo_level, 4);
        chk("pushpop_overflow", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            finish_step();
            chk("order_a_valid", step_valid, 1);
            chk("order_a_move", step_move, exp_a[i]);
            chk("order_a_level", fifo_level, 3 - i);
        end
        finish_step();
        chk("order_a_drained", step_valid, 0);

        // Move/gravity interleave: pending gravity with four queued moves
        push_cmd(8'h01);
        tick();
        chk("mix_busy_move", step_move, 1);
        push_cmd(8'h01);
        push_cmd(8'h02);
        push_cmd(8'h03);
        push_cmd(8'h04);
        chk("mix_level", fifo_level, 4);
        paused = 1'b0;
        repeat (7) tick();
        paused = 1'b1;
        chk("mix_still_busy", step_move, 1);
        for (int i = 0; i < 5; i++) begin
            finish_step();
            chk("order_b_valid", step_valid, 1);
            chk("order_b_move", step_move, exp_b[i]);
        end
        finish_step();
        chk("order_b_drained", step_valid, 0);

        // Stalled executioner, then reset mid-BUSY
        push_cmd(8'h02);
        tick();
        push_cmd(8'h03);
        chk("stall_level", fifo_level, 1);
        for (int i = 0; i < 100; i++) begin
            frame_start = (i % 20 == 0);
            tick();
            chk("stall_valid", step_valid, 1);
            chk("stall_move", step_move, 2);
            chk("stall_frame_ready", frame_ready, 0);
        end
        frame_start = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("areset_valid", step_valid, 0);
        chk("areset_move", step_move, 0);
        chk("areset_frame_ready", frame_ready, 0);
        chk("areset_level", fifo_level, 0);
        chk("areset_overflow", overflow, 0);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("post_reset_valid", step_valid, 0);
        chk("post_reset_frame_ready", frame_ready, 0);
        chk("post_reset_level", fifo_level, 0);

`ifdef GAME_SCHED_PAUSE_CMD_EN
        // Pause command freezes the counter at 1; resume continues from 1
        paused = 1'b0;
        push_cmd(8'h06);
        chk("pcmd_level", fifo_level, 0);
        repeat (20) tick();
        chk("pcmd_frozen_valid", step_valid, 0);
        chk("pcmd_frozen_level", fifo_level, 0);
        push_cmd(8'h06);
        repeat (7) tick();
        chk("pcmd_resume_early", step_valid, 0);
        tick();
        chk("pcmd_resume_valid", step_valid, 1);
        chk("pcmd_resume_move", step_move, 0);
        paused = 1'b1;
        finish_step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
